// File: rtl/pri_req_gen.sv
// Request-side initiator for the pSLIP priority max-select stage: per-input,
// per-priority occupancy counters, snapshot/issue/wait/dequeue handshake.
module pri_req_gen #(
  parameter int N  = 4,
  parameter int P  = 16,
  parameter int CW = 4,
  parameter int TO = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N-1:0]                     enq_valid,
  input  logic [0:N-1][$clog2(P)-1:0]      enq_pri,
  output logic [N-1:0]                     enq_ready,
  output logic [0:N-1][$clog2(P)-1:0]      pri_out,
  output logic                             update,
  input  logic                             sel_ready,
  input  logic [N-1:0]                     sel_req,
  output logic                             deq_valid,
  output logic [N-1:0]                     deq_mask,
  output logic                             busy,
  output logic                             err_timeout
);

  localparam int PW = $clog2(P);
  localparam int TW = $clog2(TO + 1);
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DEQ} state_t;

  state_t                  state_q, state_d;
  logic [0:N-1][PW-1:0]    pri_out_q, pri_out_d, hi;
  logic                    update_q, update_d;
  logic                    deq_valid_q, deq_valid_d;
  logic [N-1:0]            deq_mask_q, deq_mask_d;
  logic                    err_q, err_d;
  logic [TW-1:0]           wait_q, wait_d;
  logic [N-1:0]            nz;
  logic [CW-1:0]           cnt_q [N][P];
  logic [CW-1:0]           cnt_d [N][P];

  always_comb begin
    hi = '0;
    for (int i = 0; i < N; i++) begin
      for (int p = 1; p < P; p++) begin
        if (cnt_q[i][p] != '0) hi[i] = PW'(p);
      end
    end
  end

  // enq_ready looks at the current count, so a full counter being dequeued still refuses
  always_comb begin
    enq_ready = '0;
    for (int i = 0; i < N; i++) begin
      enq_ready[i] = (enq_pri[i] != '0) && (cnt_q[i][enq_pri[i]] != CMAX);
    end
  end

  always_comb begin
    nz = '0;
    for (int i = 0; i < N; i++) nz[i] = (pri_out_q[i] != '0);
  end

  always_comb begin
    logic inc, dec;
    cnt_d = cnt_q;
    for (int i = 0; i < N; i++) begin
      for (int p = 0; p < P; p++) begin
        inc = enq_valid[i] && enq_ready[i] && (enq_pri[i] == PW'(p));
        dec = (state_q == DEQ) && deq_mask_q[i] && (pri_out_q[i] == PW'(p));
        if (inc && !dec)      cnt_d[i][p] = cnt_q[i][p] + CW'(1);
        else if (dec && !inc) cnt_d[i][p] = cnt_q[i][p] - CW'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pri_out_d   = pri_out_q;
    update_d    = 1'b0;
    deq_valid_d = 1'b0;
    deq_mask_d  = '0;
    err_d       = err_q;
    wait_d      = wait_q;
    case (state_q)
      IDLE: begin
        if (|hi) begin
          pri_out_d = hi;
          update_d  = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        wait_d  = TW'(1);
        state_d = WAIT;
      end
      WAIT: begin
        if (sel_ready) begin
          // winner bits on a zero snapshot level are dropped here
          deq_valid_d = 1'b1;
          deq_mask_d  = sel_req & nz;
          state_d     = DEQ;
        end else if (wait_q == TW'(TO)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      DEQ: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pri_out_q   <= '0;
      update_q    <= 1'b0;
      deq_valid_q <= 1'b0;
      deq_mask_q  <= '0;
      err_q       <= 1'b0;
      wait_q      <= '0;
      for (int i = 0; i < N; i++) begin
        for (int p = 0; p < P; p++) cnt_q[i][p] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pri_out_q   <= pri_out_d;
      update_q    <= update_d;
      deq_valid_q <= deq_valid_d;
      deq_mask_q  <= deq_mask_d;
      err_q       <= err_d;
      wait_q      <= wait_d;
      cnt_q       <= cnt_d;
    end
  end

  assign pri_out     = pri_out_q;
  assign update      = update_q;
  assign deq_valid   = deq_valid_q;
  assign deq_mask    = deq_mask_q;
  assign err_timeout = err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_pri_req_gen.sv
// Directed bench for pri_req_gen: expected values are hand-derived cycle by cycle.
module tb_pri_req_gen;

  logic             clk;
  logic             reset;
  logic [3:0]       enq_valid;
  logic [0:3][3:0]  enq_pri;
  logic [3:0]       enq_ready;
  logic [0:3][3:0]  pri_out;
  logic             update;
  logic             sel_ready;
  logic [3:0]       sel_req;
  logic             deq_valid;
  logic [3:0]       deq_mask;
  logic             busy;
  logic             err_timeout;

  int errors = 0;
  int checks = 0;

  pri_req_gen #(.N(4), .P(16), .CW(4), .TO(8)) dut (
    .clk(clk), .reset(reset),
    .enq_valid(enq_valid), .enq_pri(enq_pri), .enq_ready(enq_ready),
    .pri_out(pri_out), .update(update),
    .sel_ready(sel_ready), .sel_req(sel_req),
    .deq_valid(deq_valid), .deq_mask(deq_mask),
    .busy(busy), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Entered at the ISSUE cycle; returns at the DEQ cycle.
  task automatic txn(input string tag, input logic [0:3][3:0] exp_pri,
                     input logic [3:0] win, input logic [3:0] exp_mask,
                     input logic [3:0] w_valid, input logic [0:3][3:0] w_pri);
    chk({tag, "_upd"}, {31'd0, update}, 32'd1);
    chk({tag, "_pri"}, pri_out, exp_pri);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      enq_valid = (k == 1) ? w_valid : 4'b0000;
      enq_pri   = w_pri;
      chk({tag, "_wait"}, {update, deq_valid, busy}, 3'b001);
      chk({tag, "_hold"}, pri_out, exp_pri);
      if (k == 5) begin
        sel_ready = 1'b1;
        sel_req   = win;
      end
    end
    cyc();
    sel_ready = 1'b0;
    sel_req   = 4'b0000;
    enq_valid = 4'b0000;
    chk({tag, "_deqv"}, {deq_valid, busy}, 2'b11);
    chk({tag, "_mask"}, deq_mask, exp_mask);
  endtask

  // A counter must never be decremented from zero.
  always @(negedge clk) begin
    if (!reset && deq_valid) begin
      for (int i = 0; i < 4; i++) begin
        if (deq_mask[i]) begin
          checks++;
          assert (dut.cnt_q[i][pri_out[i]] != 4'd0) else begin
            errors++;
            $error("FAIL underflow input=%0d observed=0 expected=nonzero", i);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enq_valid = '0; enq_pri = '0; sel_ready = 1'b0; sel_req = '0;
    cyc();
    chk("rst_outs", {update, deq_valid, deq_mask, busy, err_timeout}, 0);
    chk("rst_pri", pri_out, 0);
    reset = 1'b0;

    for (int k = 0; k < 20; k++) begin
      cyc();
      chk("idle_quiet", {update, busy, deq_valid, deq_mask, err_timeout, pri_out}, 0);
    end

    // single arrival input 2 level 9
    enq_valid = 4'b0100; enq_pri = {4'd0, 4'd0, 4'd9, 4'd0};
    #1 chk("t2_rdy", enq_ready, 4'b0100);
    cyc();
    enq_valid = '0;
    chk("t2_noupd", {31'd0, update}, 0);
    chk("t2_cnt1", dut.cnt_q[2][9], 1);
    cyc();
    txn("t2", {4'd0, 4'd0, 4'd9, 4'd0}, 4'b0100, 4'b0100, 4'b0000, '0);
    cyc();
    chk("t2_cnt0", dut.cnt_q[2][9], 0);
    chk("t2_idle", {busy, deq_valid}, 0);

    // inputs 0/1/3 at 5/12/12
    enq_valid = 4'b1011; enq_pri = {4'd5, 4'd12, 4'd0, 4'd12};
    cyc();
    enq_valid = '0;
    cyc();
    txn("t3", {4'd5, 4'd12, 4'd0, 4'd12}, 4'b1010, 4'b1010, 4'b0000, '0);
    cyc();
    chk("t3_c1", dut.cnt_q[1][12], 0);
    chk("t3_c3", dut.cnt_q[3][12], 0);
    chk("t3_c0", dut.cnt_q[0][5], 1);
    cyc();
    txn("t3b", {4'd5, 4'd0, 4'd0, 4'd0}, 4'b1111, 4'b0001, 4'b0000, '0);
    cyc();
    chk("t3b_c0", dut.cnt_q[0][5], 0);

    // arrival at 15 during WAIT with snapshot 3
    enq_valid = 4'b0010; enq_pri = {4'd0, 4'd3, 4'd0, 4'd0};
    cyc();
    enq_valid = '0;
    cyc();
    txn("t4", {4'd0, 4'd3, 4'd0, 4'd0}, 4'b0010, 4'b0010, 4'b0010, {4'd0, 4'd15, 4'd0, 4'd0});
    cyc();
    chk("t4_c3", dut.cnt_q[1][3], 0);
    chk("t4_c15", dut.cnt_q[1][15], 1);
    cyc();
    txn("t4b", {4'd0, 4'd15, 4'd0, 4'd0}, 4'b0010, 4'b0010, 4'b0000, '0);
    cyc();
    chk("t4b_idle", {busy, deq_valid}, 0);
    sel_ready = 1'b1; sel_req = 4'b1111;
    cyc();
    sel_ready = 1'b0; sel_req = '0;
    chk("idle_ready_ignored", {busy, deq_valid, update}, 0);

    // saturation on input 0 level 7, with two transactions running alongside
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) cyc();
      enq_valid = (k == 16) ? 4'b0011 : 4'b0001;
      enq_pri   = {4'd7, 4'd0, 4'd0, 4'd0};
      sel_ready = (k == 7 || k == 15);
      sel_req   = (k == 15) ? 4'b0001 : 4'b0000;
      #1;
      chk("sat_rdy", enq_ready, {3'b000, k < 15});
      chk("sat_upd", {31'd0, update}, {31'd0, (k == 2 || k == 10)});
      chk("sat_deqv", {31'd0, deq_valid}, {31'd0, (k == 8 || k == 16)});
      chk("sat_mask", deq_mask, (k == 16) ? 4'b0001 : 4'b0000);
    end
    cyc();
    enq_valid = '0; sel_ready = 1'b0; sel_req = '0;
    chk("sat_cnt14", dut.cnt_q[0][7], 14);
    chk("sat_lvl0", dut.cnt_q[1][0], 0);

    // timeout: no sel_ready
    cyc();
    chk("to_upd", {update, busy}, 2'b11);
    chk("to_pri", pri_out, {4'd7, 4'd0, 4'd0, 4'd0});
    for (int j = 1; j <= 8; j++) begin
      cyc();
      chk("to_wait", {busy, err_timeout, deq_valid}, 3'b100);
    end
    cyc();
    chk("to_err", {busy, err_timeout, deq_valid}, 3'b010);
    chk("to_cnt", dut.cnt_q[0][7], 14);
    cyc();
    chk("to_reissue", {update, err_timeout}, 2'b11);
    cyc();
    cyc();
    chk("to_inwait", {31'd0, busy}, 1);
    reset = 1'b1;
    #1;
    chk("arst_outs", {update, deq_valid, deq_mask, busy, err_timeout}, 0);
    chk("arst_pri", pri_out, 0);
    chk("arst_cnt", dut.cnt_q[0][7], 0);
    cyc();
    reset = 1'b0;
    cyc();
    cyc();
    chk("post_rst", {update, busy, deq_valid, err_timeout, pri_out}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
